inst_decode: RTL and testbench

- Decode/issue stage directly downstream of the fetch unit.
- Requests an instruction from fetch and latches the 16-bit word into an instruction register (IR) when fetch reports completion.
- Splits the IR into operand fields and presents them to the execute stage under a valid/ready handshake.
- Handles NOP, HALT, illegal opcodes and pipeline flushes locally, and counts issued instructions.

---
 rtl/inst_decode.sv | 160 ++++++++++++++++
 tb/tb_inst_decode.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode.sv
// inst_decode: decode/issue stage sitting directly behind the fetch unit.
// Requests a word from fetch, latches it into the instruction register (IR),
// splits the IR into operand fields and offers them to execute under a
// valid/ready handshake. NOP, HALT, illegal opcodes and flushes are handled
// locally; issued instructions are counted.
//
// Ports:
//   clk, rst_async        clock, asynchronous active-high reset
//   fetch_req            one-cycle request for the next instruction
//   fetch_complete, inst fetch return; inst sampled only with fetch_complete
//   flush                PC redirect, drops any in-flight or pending word
//   exec_valid/ready     handshake towards execute
//   opcode, rx, ry,
//   imm8, imm10          field views of the IR (always the last latched word)
//   illegal_inst         one-cycle pulse when an illegal opcode is latched
//   halted               high once HALT has been decoded
//   inst_count           issued-instruction counter (wraps)
module inst_decode #(
    parameter logic [5:0]  OPCODE_MAX  = 6'd40,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_async,
    output logic                   fetch_req,
    input  logic                   fetch_complete,
    input  logic [15:0]            inst,
    input  logic                   flush,
    output logic                   exec_valid,
    input  logic                   exec_ready,
    output logic [5:0]             opcode,
    output logic [2:0]             rx,
    output logic [2:0]             ry,
    output logic [7:0]             imm8,
    output logic [9:0]             imm10,
    output logic                   illegal_inst,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] inst_count
);

    localparam int unsigned INST_WIDTH   = 16;
    localparam int unsigned OPCODE_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_START,
        ST_WAIT_FETCH,
        ST_ISSUE,
        ST_HALTED
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [INST_WIDTH-1:0]   ir;
    logic [OPCODE_WIDTH-1:0] new_opcode;
    logic                    ir_load;
    logic                    illegal_set;
    logic                    count_inc;

    assign new_opcode = inst[15:10];

    // State register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        next_state  = state;
        ir_load     = 1'b0;
        illegal_set = 1'b0;
        count_inc   = 1'b0;

        case (state)
            ST_START: begin
                next_state = ST_WAIT_FETCH;
            end
            ST_WAIT_FETCH: begin
                if (fetch_complete) begin
                    ir_load = 1'b1;
                    if (new_opcode == OP_NOP) begin
                        next_state = ST_START;
                    end else if (new_opcode == OP_HALT) begin
                        next_state = ST_HALTED;
                    end else if (new_opcode > OPCODE_MAX) begin
                        // Illegal words are flagged and then dropped like a NOP
                        illegal_set = 1'b1;
                        next_state  = ST_START;
                    end else begin
                        next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (exec_ready) begin
                    count_inc  = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_HALTED: begin
                next_state = ST_HALTED;
            end
            default: begin
                next_state = ST_START;
            end
        endcase

        // Flush wins over everything except HALTED; the IR load is kept
        if (flush && (state != ST_HALTED)) begin
            next_state  = ST_START;
            illegal_set = 1'b0;
            count_inc   = 1'b0;
        end
    end

    // Instruction register; unaffected by flush
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= inst;
        end
    end

    // Illegal-opcode pulse, high for the cycle after the word is latched
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            illegal_inst <= 1'b0;
        end else begin
            illegal_inst <= illegal_set;
        end
    end

    // Issued-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            inst_count <= '0;
        end else if (count_inc) begin
            inst_count <= inst_count + COUNT_WIDTH'(1);
        end
    end

    // START also holds during reset, so the request is masked by reset to keep
    // every output low while reset is asserted and pulse on the first cycle out.
    assign fetch_req  = (state == ST_START) && !rst_async;
    assign exec_valid = (state == ST_ISSUE);
    assign halted     = (state == ST_HALTED);

    assign opcode = ir[15:10];
    assign rx     = ir[9:7];
    assign ry     = ir[6:4];
    assign imm8   = ir[7:0];
    assign imm10  = ir[9:0];

endmodule

// File: tb/tb_inst_decode.sv
// Directed testbench for inst_decode. Counter width is reduced to 4 bits so
// the wrap case stays short.
module tb_inst_decode;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_async;
    logic          fetch_req;
    logic          fetch_complete;
    logic [15:0]   inst;
    logic          flush;
    logic          exec_valid;
    logic          exec_ready;
    logic [5:0]    opcode;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [7:0]    imm8;
    logic [9:0]    imm10;
    logic          illegal_inst;
    logic          halted;
    logic [CW-1:0] inst_count;

    int n_tests;
    int n_fail;
    int exp_count;

    inst_decode #(
        .OPCODE_MAX (6'd40),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst_async     (rst_async),
        .fetch_req     (fetch_req),
        .fetch_complete(fetch_complete),
        .inst          (inst),
        .flush         (flush),
        .exec_valid    (exec_valid),
        .exec_ready    (exec_ready),
        .opcode        (opcode),
        .rx            (rx),
        .ry            (ry),
        .imm8          (imm8),
        .imm10         (imm10),
        .illegal_inst  (illegal_inst),
        .halted        (halted),
        .inst_count    (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full fetch/issue/accept sequence starting from WAIT_FETCH
    task automatic issue_one(input logic [15:0] word);
        fetch_complete = 1'b1;
        inst           = word;
        step();
        fetch_complete = 1'b0;
        check("iss_valid", 32'(exec_valid), 1);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        exp_count  = (exp_count + 1) % (1 << CW);
        check("iss_req", 32'(fetch_req), 1);
        step();
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        exp_count      = 0;
        rst_async      = 1'b1;
        fetch_complete = 1'b0;
        inst           = 16'h0000;
        flush          = 1'b0;
        exec_ready     = 1'b0;
        step();
        step();

        // Reset state: every output low
        check("rst_req",     32'(fetch_req), 0);
        check("rst_valid",   32'(exec_valid), 0);
        check("rst_halted",  32'(halted), 0);
        check("rst_illegal", 32'(illegal_inst), 0);
        check("rst_count",   32'(inst_count), 0);
        check("rst_fields",  32'({opcode, rx, ry, imm8, imm10}), 0);

        // Release reset: fetch_req for exactly one cycle
        rst_async = 1'b0;
        #1;
        check("rel_req", 32'(fetch_req), 1);
        step();
        check("rel_req_drop", 32'(fetch_req), 0);

        // 16'h0A5C: opcode=2, rx=IR[9:7]=3'b100, ry=3'b101, imm8=5C, imm10=25C
        fetch_complete = 1'b1;
        inst           = 16'h0A5C;
        step();
        fetch_complete = 1'b0;
        check("t1_valid",  32'(exec_valid), 1);
        check("t1_opcode", 32'(opcode), 2);
        check("t1_rx",     32'(rx), 4);
        check("t1_ry",     32'(ry), 5);
        check("t1_imm8",   32'(imm8), 'h5C);
        check("t1_imm10",  32'(imm10), 'h25C);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        exp_count  = 1;
        check("t1_count", 32'(inst_count), 1);
        check("t1_req",   32'(fetch_req), 1);
        check("t1_novld", 32'(exec_valid), 0);
        step();

        // 16'h1234 held in ISSUE for 5 cycles; fetch_complete there is ignored
        fetch_complete = 1'b1;
        inst           = 16'h1234;
        step();
        inst = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("t2_valid",  32'(exec_valid), 1);
            check("t2_opcode", 32'(opcode), 4);
            check("t2_ry",     32'(ry), 3);
            check("t2_imm10",  32'(imm10), 'h234);
            step();
        end
        fetch_complete = 1'b0;
        exec_ready     = 1'b1;
        step();
        exec_ready = 1'b0;
        exp_count  = 2;
        check("t2_count", 32'(inst_count), 2);
        step();
        check("t2_count_once", 32'(inst_count), 2);

        // NOP then illegal opcode 44: nothing issued, one illegal pulse
        fetch_complete = 1'b1;
        inst           = 16'h0000;
        step();
        fetch_complete = 1'b0;
        check("t3_nop_valid",   32'(exec_valid), 0);
        check("t3_nop_req",     32'(fetch_req), 1);
        check("t3_nop_illegal", 32'(illegal_inst), 0);
        step();
        fetch_complete = 1'b1;
        inst           = 16'hB000;
        step();
        fetch_complete = 1'b0;
        check("t3_ill_pulse", 32'(illegal_inst), 1);
        check("t3_ill_valid", 32'(exec_valid), 0);
        check("t3_ill_req",   32'(fetch_req), 1);
        check("t3_ill_count", 32'(inst_count), 2);
        step();
        check("t3_ill_once", 32'(illegal_inst), 0);

        // flush with fetch_complete: IR loads, nothing issued
        flush          = 1'b1;
        fetch_complete = 1'b1;
        inst           = 16'h0800;
        step();
        flush          = 1'b0;
        fetch_complete = 1'b0;
        check("t5_fc_valid",  32'(exec_valid), 0);
        check("t5_fc_req",    32'(fetch_req), 1);
        check("t5_fc_irload", 32'(opcode), 2);
        step();
        // flush with the exec handshake: no count
        fetch_complete = 1'b1;
        step();
        fetch_complete = 1'b0;
        check("t5_hs_valid", 32'(exec_valid), 1);
        flush      = 1'b1;
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        check("t5_hs_count", 32'(inst_count), 2);
        check("t5_hs_req",   32'(fetch_req), 1);
        // flush still high while in START: request repeats
        step();
        flush = 1'b0;
        check("t5_start_req", 32'(fetch_req), 1);
        step();
        check("t5_wait_req", 32'(fetch_req), 0);

        // HALT: sticky, everything else ignored
        fetch_complete = 1'b1;
        inst           = 16'hFC00;
        step();
        check("t4_halted", 32'(halted), 1);
        inst = 16'h0A5C;
        for (int i = 0; i < 4; i++) begin
            flush      = i[0];
            exec_ready = 1'b1;
            step();
            check("t4_hold",  32'(halted), 1);
            check("t4_noreq", 32'(fetch_req), 0);
            check("t4_novld", 32'(exec_valid), 0);
        end
        fetch_complete = 1'b0;
        flush          = 1'b0;
        exec_ready     = 1'b0;
        check("t4_count", 32'(inst_count), 2);
        check("t4_ir",    32'(opcode), 'h3F);
        rst_async = 1'b1;
        #1;
        check("t4_rst_halted", 32'(halted), 0);
        check("t4_rst_count",  32'(inst_count), 0);
        step();
        rst_async = 1'b0;
        exp_count = 0;
        step();

        // Counter wrap at 2^CW
        while (exp_count != (1 << CW) - 1) begin
            issue_one(16'h0400 + 16'(exp_count));
        end
        check("t6_full", 32'(inst_count), (1 << CW) - 1);
        issue_one(16'h0401);
        check("t6_wrap", 32'(inst_count), 0);

        // Reset asserted mid-handshake drops exec_valid at once
        fetch_complete = 1'b1;
        inst           = 16'h0A5C;
        step();
        fetch_complete = 1'b0;
        check("t6_issue", 32'(exec_valid), 1);
        exec_ready = 1'b1;
        rst_async  = 1'b1;
        #1;
        check("t6_rst_valid", 32'(exec_valid), 0);
        check("t6_rst_req",   32'(fetch_req), 0);
        check("t6_rst_ir",    32'(imm10), 0);
        step();
        exec_ready = 1'b0;
        rst_async  = 1'b0;
        #1;
        check("t6_rel_req", 32'(fetch_req), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
